// File: rtl/fft_frame_sched.sv
// Ping-pong frame scheduler between the I2S sample stream and the FFT core.
// One bank fills from the sample path while the other is transformed and read out over SPI.
//
// state    | meaning
// ---------+------------------------------------------------
// IDLE     | wait until the oldest bank (proc_bank) is full
// START    | launch the FFT on proc_bank
// WAIT_FFT | wait for fft_done, then release the bank
// TX       | launch the SPI readout
// WAIT_TX0 | guard cycle so tx_busy has time to rise
// WAIT_TX  | wait for the readout to finish, count the frame
module fft_frame_sched #(
   parameter int N_LOG2 = 5,
   parameter int DW     = 32,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DW-1:0]     sample_in,
   input  logic              sample_valid,
   output logic              buf_we,
   output logic [N_LOG2:0]   buf_waddr,
   output logic [DW-1:0]     buf_wdata,
   output logic              fft_start,
   output logic              fft_bank,
   input  logic              fft_done,
   output logic              tx_start,
   input  logic              tx_busy,
   output logic              done,
   output logic              overrun,
   output logic [CNT_W-1:0]  frame_cnt
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      START    = 3'd1,
      WAIT_FFT = 3'd2,
      TX       = 3'd3,
      WAIT_TX0 = 3'd4,
      WAIT_TX  = 3'd5
   } state_t;

   localparam logic [N_LOG2-1:0] IDX_LAST = '1;

   state_t              state;
   state_t              state_nxt;
   logic                wr_bank;
   logic [N_LOG2-1:0]   wr_idx;
   logic [1:0]          full;
   logic [1:0]          full_nxt;
   logic                proc_bank;
   logic                accept;
   logic                drop;
   logic                frame_last;
   logic                bank_release;
   logic                frame_fin;

   // Acceptance uses the registered full flag, so a bank freed this cycle
   // still drops a sample that arrives in the same cycle.
   assign accept     = sample_valid & ~full[wr_bank];
   assign drop       = sample_valid &  full[wr_bank];
   assign frame_last = accept & (wr_idx == IDX_LAST);

   always_comb begin
      state_nxt    = state;
      bank_release = 1'b0;
      frame_fin    = 1'b0;
      case (state)
         IDLE:     if (full[proc_bank]) state_nxt = START;
         START:    state_nxt = WAIT_FFT;
         WAIT_FFT: begin
            if (fft_done) begin
               bank_release = 1'b1;
               state_nxt    = TX;
            end
         end
         TX:       state_nxt = WAIT_TX0;
         WAIT_TX0: state_nxt = WAIT_TX;
         WAIT_TX: begin
            if (!tx_busy) begin
               frame_fin = 1'b1;
               state_nxt = IDLE;
            end
         end
         default:  state_nxt = IDLE;
      endcase
   end

   // Release and fill always address different banks, so both apply together.
   always_comb begin
      full_nxt = full;
      if (bank_release) full_nxt[proc_bank] = 1'b0;
      if (frame_last)   full_nxt[wr_bank]   = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_bank   <= 1'b0;
         wr_idx    <= '0;
         full      <= 2'b00;
         buf_we    <= 1'b0;
         buf_waddr <= '0;
         buf_wdata <= '0;
         overrun   <= 1'b0;
      end else begin
         full   <= full_nxt;
         buf_we <= accept;
         if (accept) begin
            buf_waddr <= {wr_bank, wr_idx};
            buf_wdata <= sample_in;
            wr_idx    <= wr_idx + 1'b1;
            if (frame_last) wr_bank <= ~wr_bank;
         end
         if (drop) overrun <= 1'b1;
      end
   end

   // Strobes are registered; fft_bank is captured while START so it is
   // already settled when fft_start is seen by the core.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         proc_bank <= 1'b0;
         fft_start <= 1'b0;
         fft_bank  <= 1'b0;
         tx_start  <= 1'b0;
         done      <= 1'b0;
         frame_cnt <= '0;
      end else begin
         state     <= state_nxt;
         fft_start <= (state == START);
         tx_start  <= bank_release;
         done      <= frame_fin;
         if (state == START) fft_bank <= proc_bank;
         if (frame_fin) begin
            proc_bank <= ~proc_bank;
            frame_cnt <= frame_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fft_frame_sched.sv
// Bench for fft_frame_sched: acts as FFT core and SPI master, and checks every cycle
// against a frame-level reference model (linear write pointer, queue of filled frames).
module tb_fft_frame_sched;

   localparam int N_LOG2 = 5;
   localparam int DW     = 32;
   localparam int CNT_W  = 8;
   localparam int N      = 1 << N_LOG2;

   logic              clk = 1'b0;
   logic              reset;
   logic [DW-1:0]     sample_in;
   logic              sample_valid;
   logic              buf_we;
   logic [N_LOG2:0]   buf_waddr;
   logic [DW-1:0]     buf_wdata;
   logic              fft_start;
   logic              fft_bank;
   logic              fft_done;
   logic              tx_start;
   logic              tx_busy;
   logic              done;
   logic              overrun;
   logic [CNT_W-1:0]  frame_cnt;

   fft_frame_sched #(.N_LOG2(N_LOG2), .DW(DW), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
      .buf_we(buf_we), .buf_waddr(buf_waddr), .buf_wdata(buf_wdata),
      .fft_start(fft_start), .fft_bank(fft_bank), .fft_done(fft_done),
      .tx_start(tx_start), .tx_busy(tx_busy), .done(done),
      .overrun(overrun), .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   int pass_cnt = 0;
   int chk_cnt  = 0;
   int cyc      = 0;

   // reference model
   typedef struct { int bank; int t; } frame_t;
   frame_t          pq[$];
   bit              m_full [2];
   int              m_wpos, cnt, last_done, cur_bank;
   bit              m_ovr, busy_proc, waiting_fft, waiting_tx;
   bit              exp_we;
   int              exp_addr, exp_tx, exp_done, tx_from;
   logic [DW-1:0]   exp_data;

   // responder / stimulus controls
   int  fft_done_at, busy_from, busy_until, fft_dly, tx_len;
   bit  rand_dly, hold, spur;
   int  dut_banks[$];
   int  tx_seen, last_fs_cyc, last_fd_cyc, last_tx_cyc;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      chk_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
   endtask

   function automatic int pick_dly(input int fixed, input int lo, input int hi);
      if (!rand_dly) return fixed;
      if ($urandom_range(15, 0) == 0) return int'($urandom_range(90, 40));
      return int'($urandom_range(hi, lo));
   endfunction

   task automatic model_reset();
      pq.delete();
      m_full[0] = 0; m_full[1] = 0;
      m_wpos = 0; cnt = 0; last_done = -1000; cur_bank = 0;
      m_ovr = 0; busy_proc = 0; waiting_fft = 0; waiting_tx = 0;
      exp_we = 0; exp_addr = 0; exp_data = '0; exp_tx = -1; exp_done = -1; tx_from = 0;
      fft_done_at = -1; busy_from = 1; busy_until = 0;
   endtask

   task automatic step(input logic sv, input logic [DW-1:0] din);
      int  b, ts;
      bit  exp_fs;
      @(posedge clk); #1;
      cyc++;
      sample_valid = sv;
      sample_in    = din;
      fft_done     = spur || (cyc == fft_done_at);
      tx_busy      = (cyc >= busy_from) && (cyc <= busy_until);
      @(negedge clk);
      if (fft_start) begin dut_banks.push_back(int'(fft_bank)); last_fs_cyc = cyc; end
      if (fft_done) last_fd_cyc = cyc;
      if (tx_start) begin tx_seen++; last_tx_cyc = cyc; end

      chk("buf_we", 64'(buf_we), 64'(exp_we));
      if (exp_we) begin
         chk("buf_waddr", 64'(buf_waddr), 64'(exp_addr));
         chk("buf_wdata", 64'(buf_wdata), 64'(exp_data));
      end
      exp_fs = 0;
      if (pq.size() > 0 && !busy_proc) begin
         ts = pq[0].t + 3;
         if (last_done + 2 > ts) ts = last_done + 2;
         exp_fs = (cyc == ts);
      end
      chk("fft_start", 64'(fft_start), 64'(exp_fs));
      if (exp_fs) begin
         cur_bank = pq[0].bank;
         pq.pop_front();
         busy_proc   = 1;
         waiting_fft = 1;
         fft_done_at = hold ? -1 : cyc + pick_dly(fft_dly, 1, 12);
      end
      if (waiting_fft) chk("fft_bank", 64'(fft_bank), 64'(cur_bank));
      chk("tx_start", 64'(tx_start), 64'(cyc == exp_tx));
      if (cyc == exp_tx) begin
         busy_from  = cyc + 1;
         busy_until = cyc + pick_dly(tx_len, 1, 12);
         waiting_tx = 1;
         tx_from    = cyc + 2;
      end
      chk("done", 64'(done), 64'(cyc == exp_done));
      if (cyc == exp_done) begin
         cnt++;
         busy_proc = 0;
         last_done = cyc;
      end
      chk("frame_cnt", 64'(frame_cnt), 64'(cnt % 256));
      chk("overrun", 64'(overrun), 64'(m_ovr));

      // effects of this cycle's inputs, visible from the next cycle
      exp_we = 0;
      if (sample_valid) begin
         b = m_wpos / N;
         if (!m_full[b]) begin
            exp_we   = 1;
            exp_addr = m_wpos;
            exp_data = sample_in;
            m_wpos   = (m_wpos + 1) % (2 * N);
            if (m_wpos % N == 0) begin
               m_full[b] = 1;
               pq.push_back('{bank: b, t: cyc});
            end
         end else begin
            m_ovr = 1;
         end
      end
      if (fft_done && waiting_fft) begin
         m_full[cur_bank] = 0;
         waiting_fft = 0;
         exp_tx = cyc + 1;
      end
      if (waiting_tx && cyc >= tx_from && !tx_busy) begin
         exp_done   = cyc + 1;
         waiting_tx = 0;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #1;
      chk("rst_outs", 64'({buf_we, buf_waddr, buf_wdata, fft_start, fft_bank,
                           tx_start, done, overrun, frame_cnt}), 64'(0));
      sample_valid = 0; fft_done = 0; tx_busy = 0; spur = 0;
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;
      model_reset();
      dut_banks.delete();
   endtask

   task automatic run_until_frames(input int target, input int budget, input string tag);
      for (int k = 0; k < budget && cnt < target; k++) step(1'b0, $urandom());
      chk(tag, 64'(cnt >= target), 64'(1));
   endtask

   initial begin
      int t32;
      reset = 1'b1; sample_valid = 0; sample_in = '0; fft_done = 0; tx_busy = 0;
      rand_dly = 0; hold = 0; spur = 0; fft_dly = 100; tx_len = 50; tx_seen = 0;
      last_fs_cyc = -1; last_fd_cyc = -1; last_tx_cyc = -1; t32 = 0;
      model_reset();
      #1;
      chk("reset_state", 64'({buf_we, buf_waddr, buf_wdata, fft_start, fft_bank,
                              tx_start, done, overrun, frame_cnt}), 64'(0));
      @(posedge clk); #1;
      reset = 1'b0;

      // single frame, sparse strobes, slow FFT and readout
      for (int i = 0; i < N; i++) begin
         step(1'b1, DW'(i));
         if (i == N - 1) t32 = cyc;
         for (int j = 0; j < 15; j++) step(1'b0, $urandom());
      end
      run_until_frames(1, 400, "p1_budget");
      chk("p1_fs_latency", 64'(last_fs_cyc - t32), 64'(3));
      chk("p1_fft_bank", 64'(dut_banks.size() == 1 ? dut_banks[0] : -1), 64'(0));
      chk("p1_tx_latency", 64'(last_tx_cyc - last_fd_cyc), 64'(1));
      chk("p1_frame_cnt", 64'(frame_cnt), 64'(1));

      // both banks fill while fft_done is withheld
      do_reset();
      hold = 1; fft_dly = 10; tx_len = 5;
      for (int i = 0; i < 70; i++) step(1'b1, $urandom());
      chk("p3_overrun", 64'(overrun), 64'(1));
      hold = 0;
      if (waiting_fft) fft_done_at = cyc + 3;
      for (int i = 0; i < 60; i++) step(1'b1, $urandom());
      chk("p3_overrun_sticky", 64'(overrun), 64'(1));

      // three back-to-back frames, immediate FFT/readout
      do_reset();
      fft_dly = 1; tx_len = 1;
      for (int i = 0; i < 3 * N; i++) step(1'b1, $urandom());
      run_until_frames(3, 100, "p4_budget");
      chk("p4_nstarts", 64'(dut_banks.size()), 64'(3));
      if (dut_banks.size() == 3) begin
         chk("p4_bank0", 64'(dut_banks[0]), 64'(0));
         chk("p4_bank1", 64'(dut_banks[1]), 64'(1));
         chk("p4_bank2", 64'(dut_banks[2]), 64'(0));
      end
      chk("p4_frame_cnt", 64'(frame_cnt), 64'(3));
      chk("p4_overrun", 64'(overrun), 64'(0));

      // reset while the FFT is busy on bank 1 and bank 0 is part-filled
      hold = 1;
      for (int k = 0; k < 200 && !(waiting_fft && (m_wpos % N) >= 5); k++)
         step(1'b1, $urandom());
      chk("p5_reach_wait", 64'(waiting_fft), 64'(1));
      do_reset();
      hold = 0; fft_dly = 20; tx_len = 8;
      for (int i = 0; i < N; i++) step(1'b1, $urandom());
      run_until_frames(1, 200, "p5_budget");
      chk("p5_fft_bank", 64'(dut_banks.size() > 0 ? dut_banks[0] : -1), 64'(0));

      // 256 frames with random gaps and delays
      do_reset();
      rand_dly = 1;
      for (int k = 0; k < 40000 && cnt < 256; k++)
         step($urandom_range(7, 0) != 0, $urandom());
      chk("p6_budget", 64'(cnt >= 256), 64'(1));
      chk("p6_wrap", 64'(frame_cnt), 64'(cnt % 256));
      for (int k = 0; k < 500 && (pq.size() > 0 || busy_proc); k++) step(1'b0, $urandom());
      chk("p6_idle", 64'(busy_proc), 64'(0));
      spur = 1;
      step(1'b0, $urandom());
      spur = 0;
      tx_seen = 0;
      for (int k = 0; k < 12; k++) step(1'b0, $urandom());
      chk("spur_tx", 64'(tx_seen), 64'(0));

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/fft_frame_sched.md
Name: fft_frame_sched

Overview:
- Frame scheduler between the I2S sample path and the FFT core.
- Collects `sample_valid`-qualified samples into a two-bank (ping-pong) frame buffer.
- When a bank holds a full frame: launches the FFT on it, waits for completion, then launches the SPI result readout.
- Flags frames lost because both banks are occupied.

Parameters:
- N_LOG2, 5, log2 of FFT frame length N (default 32 points).
- DW, 32, sample width.
- CNT_W, 8, width of completed-frame counter.

Ports:
- clk  in  1  system clock (48 MHz domain).
- reset  in  1  asynchronous, active-high reset.
- sample_in  in  DW  sample data, valid when sample_valid=1.
- sample_valid  in  1  one-cycle strobe per new sample.
- buf_we  out  1  frame-buffer write enable.
- buf_waddr  out  N_LOG2+1  write address, {bank, index}.
- buf_wdata  out  DW  write data.
- fft_start  out  1  one-cycle pulse: FFT begins on bank fft_bank.
- fft_bank  out  1  bank the FFT reads; stable from fft_start until fft_done.
- fft_done  in  1  one-cycle pulse from FFT core: computation finished, input bank no longer needed.
- tx_start  out  1  one-cycle pulse: begin SPI readout of results.
- tx_busy  in  1  high while SPI readout is in progress.
- done  out  1  one-cycle pulse when a frame's readout finishes.
- overrun  out  1  sticky flag: at least one sample dropped.
- frame_cnt  out  CNT_W  completed frames, wraps modulo 2^CNT_W.

Behaviour:
- Reset (async): every output 0; wr_bank=0, wr_idx=0, full[1:0]=0, proc_bank=0, FSM=IDLE.
- Write side:
  - A sample is accepted when sample_valid=1 and full[wr_bank]=0, using the registered value of full.
  - On acceptance, in the next cycle: buf_we=1, buf_waddr={wr_bank,wr_idx}, buf_wdata=sample_in (latched). Write latency is 1 cycle.
  - wr_idx increments on each accept. The accept at wr_idx=N-1 sets full[wr_bank], toggles wr_bank and clears wr_idx at the same edge.
- Drop:
  - sample_valid=1 while full[wr_bank]=1 discards the sample: no buf_we, wr_idx unchanged, overrun<=1.
  - overrun clears only on reset.
  - If a bank is freed in the same cycle a sample arrives for it, that sample is still dropped.
- Processing FSM, states IDLE, START, WAIT_FFT, TX, WAIT_TX0, WAIT_TX:
  - IDLE: if full[proc_bank] -> START.
  - START: fft_start=1, fft_bank=proc_bank -> WAIT_FFT.
  - WAIT_FFT: on fft_done, clear full[proc_bank] -> TX. fft_done seen in any other state is ignored.
  - TX: tx_start=1 -> WAIT_TX0.
  - WAIT_TX0: one-cycle guard for tx_busy to rise -> WAIT_TX.
  - WAIT_TX: when tx_busy=0: done=1, frame_cnt+1, proc_bank toggles -> IDLE.
- Banks are processed strictly in fill order. proc_bank always points at the oldest filled bank.
- Write side keeps filling the other bank while the FSM is in any state.
- Latencies:
  - Last accepted sample of frame -> fft_start: 3 cycles when FSM is IDLE (full set; IDLE sees it; START).
  - fft_done -> tx_start: 1 cycle.
- Clearing full (FSM) and setting full (write side) target different banks by construction. Both updates apply in the same cycle without conflict.
- frame_cnt wraps 2^CNT_W-1 -> 0 silently.
- Reset mid-frame or mid-FFT abandons all state. The FFT core and SPI are reset by the same reset.

Test Plan:
- Reset, then 32 sample_valid strobes with sample_in=i, spaced 16 cycles:
  - buf_we pulses at addr 0..31 with data 0..31.
  - fft_start 3 cycles after the 32nd strobe, fft_bank=0.
- fft_done returned 100 cycles after fft_start, tx_busy high 50 cycles after tx_start:
  - tx_start 1 cycle after fft_done.
  - done pulse when tx_busy falls.
  - frame_cnt=1.
- Continuous samples, fft_done withheld:
  - bank1 fills at addr 32..63.
  - the 65th sample is dropped, overrun=1, no buf_we.
  - after fft_done, the next sample writes addr 0.
- 3 back-to-back frames with immediate fft_done/tx:
  - fft_bank sequence 0,1,0; frame_cnt=3; overrun=0.
- Assert reset during WAIT_FFT:
  - all outputs 0 immediately (async).
  - next frame starts at addr 0 and fft_bank=0.
- 256 frames:
  - frame_cnt wraps to 0.
  - spurious fft_done in IDLE produces no tx_start.
